alu_issue_stage: RTL and testbench

- Producer end of the execute-stage ALU interface: decodes opcode/funct fields into the 4-bit ALU control code and WordOp, and selects and forwards operands.
- Registers the results toward the ALU with a valid/ready handshake and a one-entry skid buffer.
- Sits between the decode stage and the ALU; absorbs execute-side stalls without combinational ready paths back into decode.

---
 rtl/alu_pkg.sv | 54 +++++
 rtl/alu_ctrl_decode.sv | 75 +++++++
 rtl/alu_issue_stage.sv | 181 ++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the execute-stage ALU issue path.
//   - ALU control codes driven on alu_control
//   - major opcode values (instruction[6:0])
//   - forwarding-select encodings for fwd_a_sel / fwd_b_sel
//   - operand2 source select and issue-stage state encodings
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_PASS = 4'b1000;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_RW     = 7'b0111011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_IW     = 7'b0011011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] FWD_REG    = 2'b00;
  localparam logic [1:0] FWD_EX_MEM = 2'b01;
  localparam logic [1:0] FWD_MEM_WB = 2'b10;

  typedef enum logic [1:0] {OP2_RS2, OP2_IMM, OP2_FOUR} op2_sel_e;

  typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} issue_state_e;

  // Full-width integer ops shared by R and I formats. Returns {illegal, ctrl}.
  function automatic logic [4:0] int_op_ctrl(input logic [2:0] f3, input logic sub);
    logic [4:0] r;
    case (f3)
      3'b000:  r = {1'b0, sub ? ALU_SUB : ALU_ADD};
      3'b111:  r = {1'b0, ALU_AND};
      3'b110:  r = {1'b0, ALU_OR};
      3'b100:  r = {1'b0, ALU_XOR};
      3'b010:  r = {1'b0, ALU_SLT};
      3'b001:  r = {1'b0, ALU_SLL};
      3'b101:  r = {1'b0, ALU_SRL};
      default: r = {1'b1, ALU_ADD};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: combinational decode of opcode/funct3/funct7_5.
// Ports:
//   opcode_i, funct3_i, funct7_5_i : instruction fields
//   alu_control_o : ALU operation code (ADD when illegal)
//   word_op_o     : 32-bit operation
//   illegal_o     : unsupported encoding
//   op1_pc_o      : operand1 comes from PC instead of forwarded rs1
//   op2_sel_o     : operand2 source (forwarded rs2 / imm / constant 4)
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  output logic [3:0] alu_control_o,
  output logic       word_op_o,
  output logic       illegal_o,
  output logic       op1_pc_o,
  output op2_sel_e   op2_sel_o
);

  logic [4:0] int_r;

  always_comb begin
    alu_control_o = ALU_ADD;
    word_op_o     = 1'b0;
    illegal_o     = 1'b0;
    op1_pc_o      = 1'b0;
    op2_sel_o     = OP2_RS2;
    int_r         = 5'b0;
    case (opcode_i)
      OP_R: begin
        int_r         = int_op_ctrl(funct3_i, funct7_5_i);
        {illegal_o, alu_control_o} = int_r;
      end
      OP_I: begin
        // funct7_5 on an immediate ADD is an immediate bit, never SUB
        int_r         = int_op_ctrl(funct3_i, 1'b0);
        {illegal_o, alu_control_o} = int_r;
        op2_sel_o     = OP2_IMM;
      end
      OP_RW, OP_IW: begin
        word_op_o = 1'b1;
        if (opcode_i == OP_IW) op2_sel_o = OP2_IMM;
        case (funct3_i)
          3'b000:  alu_control_o = (opcode_i == OP_RW && funct7_5_i) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control_o = ALU_SLL;
          3'b101:  alu_control_o = ALU_SRL;
          default: illegal_o     = 1'b1;
        endcase
      end
      OP_LOAD, OP_STORE: op2_sel_o = OP2_IMM;
      OP_BRANCH:         alu_control_o = ALU_SUB;
      OP_LUI: begin
        alu_control_o = ALU_PASS;
        op2_sel_o     = OP2_IMM;
      end
      OP_AUIPC: begin
        op1_pc_o  = 1'b1;
        op2_sel_o = OP2_IMM;
      end
      OP_JAL, OP_JALR: begin
        op1_pc_o  = 1'b1;
        op2_sel_o = OP2_FOUR;
      end
      default: illegal_o = 1'b1;
    endcase
    // An illegal word op carries no meaningful width
    if (illegal_o) begin
      alu_control_o = ALU_ADD;
      word_op_o     = 1'b0;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes, forwards and registers ALU operands toward execute
// behind a valid/ready handshake with a one-entry skid buffer, so in_ready is
// a pure flop output and never depends combinationally on out_ready.
// Ports:
//   clk, rst, flush          : clock, sync active-high reset, sync flush
//   in_valid / in_ready      : decode-side handshake
//   opcode, funct3, funct7_5 : instruction fields
//   pc, rs1_data, rs2_data, imm, fwd_a_sel, fwd_b_sel,
//   ex_mem_result, mem_wb_result : operand sources
//   out_valid / out_ready    : execute-side handshake
//   operand1, operand2, alu_control, word_op, store_data, illegal : issued op
//   issued_cnt, stall_cnt    : performance counters (ALU_ISSUE_PERF_EN),
//                              tied to zero when the macro is undefined
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int              XLEN       = 64,
  parameter logic [XLEN-1:0] RST_PC_OPS = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic            funct7_5,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic [1:0]      fwd_a_sel,
  input  logic [1:0]      fwd_b_sel,
  input  logic [XLEN-1:0] ex_mem_result,
  input  logic [XLEN-1:0] mem_wb_result,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] operand1,
  output logic [XLEN-1:0] operand2,
  output logic [3:0]      alu_control,
  output logic            word_op,
  output logic [XLEN-1:0] store_data,
  output logic            illegal,
  output logic [31:0]     issued_cnt,
  output logic [31:0]     stall_cnt
);

  typedef struct packed {
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] sdata;
    logic [3:0]      ctrl;
    logic            word_op;
    logic            illegal;
  } entry_t;

  issue_state_e state_q, state_d;
  entry_t       out_q, skid_q, new_op, rst_entry;

  logic [3:0]      dec_ctrl;
  logic            dec_word, dec_illegal, dec_op1_pc;
  op2_sel_e        dec_op2_sel;
  logic [XLEN-1:0] fwd_a, fwd_b;
  logic            accept, xfer_out;

  alu_ctrl_decode u_decode (
    .opcode_i      (opcode),
    .funct3_i      (funct3),
    .funct7_5_i    (funct7_5),
    .alu_control_o (dec_ctrl),
    .word_op_o     (dec_word),
    .illegal_o     (dec_illegal),
    .op1_pc_o      (dec_op1_pc),
    .op2_sel_o     (dec_op2_sel)
  );

  always_comb begin
    case (fwd_a_sel)
      FWD_EX_MEM: fwd_a = ex_mem_result;
      FWD_MEM_WB: fwd_a = mem_wb_result;
      default:    fwd_a = rs1_data;
    endcase
    case (fwd_b_sel)
      FWD_EX_MEM: fwd_b = ex_mem_result;
      FWD_MEM_WB: fwd_b = mem_wb_result;
      default:    fwd_b = rs2_data;
    endcase
  end

  always_comb begin
    new_op.op1 = dec_op1_pc ? pc : fwd_a;
    case (dec_op2_sel)
      OP2_IMM:  new_op.op2 = imm;
      OP2_FOUR: new_op.op2 = XLEN'(4);
      default:  new_op.op2 = fwd_b;
    endcase
    new_op.sdata   = fwd_b;
    new_op.ctrl    = dec_ctrl;
    new_op.word_op = dec_word;
    new_op.illegal = dec_illegal;
  end

  assign rst_entry = '{op1: RST_PC_OPS, op2: RST_PC_OPS, sdata: RST_PC_OPS,
                       ctrl: ALU_ADD, word_op: 1'b0, illegal: 1'b0};

  assign accept   = in_valid && in_ready;
  assign xfer_out = out_valid && out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst || flush) state_q <= ST_EMPTY;
    else              state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL: begin
        if (accept && !out_ready)      state_d = ST_SKID;
        else if (!accept && out_ready) state_d = ST_EMPTY;
      end
      ST_SKID:  if (out_ready) state_d = ST_FULL;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // Outputs
  always_comb begin
    out_valid = (state_q != ST_EMPTY);
    in_ready  = (state_q != ST_SKID);
  end

  // Payload: the output register takes a new op when the slot is free or being
  // drained this cycle; otherwise the new op parks in the skid entry.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      out_q  <= rst_entry;
      skid_q <= rst_entry;
    end else begin
      if (state_q == ST_SKID) begin
        if (out_ready) out_q <= skid_q;
      end else if (accept) begin
        if (state_q == ST_EMPTY || out_ready) out_q  <= new_op;
        else                                  skid_q <= new_op;
      end
    end
  end

  assign operand1    = out_q.op1;
  assign operand2    = out_q.op2;
  assign store_data  = out_q.sdata;
  assign alu_control = out_q.ctrl;
  assign word_op     = out_q.word_op;
  assign illegal     = out_q.illegal;

`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] issued_cnt_q, stall_cnt_q;

  // Counters survive flush; only reset clears them
  always_ff @(posedge clk) begin
    if (rst) begin
      issued_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      if (xfer_out)               issued_cnt_q <= issued_cnt_q + 32'd1;
      if (out_valid && !out_ready) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign issued_cnt = issued_cnt_q;
  assign stall_cnt  = stall_cnt_q;
`else
  logic unused_perf;
  assign unused_perf = xfer_out;
  assign issued_cnt  = '0;
  assign stall_cnt   = '0;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst, flush, in_valid, in_ready;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            funct7_5;
  logic [XLEN-1:0] pc, rs1_data, rs2_data, imm, ex_mem_result, mem_wb_result;
  logic [1:0]      fwd_a_sel, fwd_b_sel;
  logic            out_valid, out_ready;
  logic [XLEN-1:0] operand1, operand2, store_data;
  logic [3:0]      alu_control;
  logic            word_op, illegal;
  logic [31:0]     issued_cnt, stall_cnt;

  int vectors = 0;
  int miscompares = 0;

  alu_issue_stage #(.XLEN(XLEN), .RST_PC_OPS('0)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .ex_mem_result(ex_mem_result), .mem_wb_result(mem_wb_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .operand1(operand1), .operand2(operand2), .alu_control(alu_control),
    .word_op(word_op), .store_data(store_data), .illegal(illegal),
    .issued_cnt(issued_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] im);
    opcode = op; funct3 = f3; funct7_5 = f7;
    rs1_data = a; rs2_data = b; imm = im;
  endtask

  task automatic check_perf(input string tag, input int iss, input int stl);
`ifdef ALU_ISSUE_PERF_EN
    check({tag, "_issued"}, 64'(issued_cnt), 64'(iss));
    check({tag, "_stall"},  64'(stall_cnt),  64'(stl));
`else
    check({tag, "_issued"}, 64'(issued_cnt), 64'(0));
    check({tag, "_stall"},  64'(stall_cnt),  64'(0));
`endif
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    fwd_a_sel = 2'b00; fwd_b_sel = 2'b00;
    pc = '0; ex_mem_result = '0; mem_wb_result = '0;
    set_op(7'b0110011, 3'b000, 1'b0, 0, 0, 0);
    step(); step();
    rst = 1'b0;

    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_in_ready",  64'(in_ready), 1);
    check("rst_illegal",   64'(illegal), 0);
    check("rst_word_op",   64'(word_op), 0);
    check("rst_ctrl",      64'(alu_control), 0);
    check("rst_op1",       operand1, 0);
    check("rst_op2",       operand2, 0);
    check("rst_sdata",     store_data, 0);
    check_perf("rst", 0, 0);

    // R SUB
    set_op(7'b0110011, 3'b000, 1'b1, 10, 3, 64'hFFFF);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("sub_valid", 64'(out_valid), 1);
    check("sub_ctrl",  64'(alu_control), 4'b0001);
    check("sub_op1",   operand1, 10);
    check("sub_op2",   operand2, 3);
    check("sub_word",  64'(word_op), 0);
    step();
    check("sub_drain", 64'(out_valid), 0);

    // ADDIW
    set_op(7'b0011011, 3'b000, 1'b0, 64'h7FFFFFFF, 64'h5, 1);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("addiw_ctrl", 64'(alu_control), 0);
    check("addiw_word", 64'(word_op), 1);
    check("addiw_op1",  operand1, 64'h7FFFFFFF);
    check("addiw_op2",  operand2, 1);
    step();

    // SRAI maps to SRL code
    set_op(7'b0010011, 3'b101, 1'b1, 7, 8, 3);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("srai_ctrl", 64'(alu_control), 4'b0111);
    step();

    // Back-to-back with stall: A=ADD, B=XOR, C=OR
    out_ready = 1'b0;
    set_op(7'b0110011, 3'b000, 1'b0, 1, 2, 0);
    in_valid = 1'b1;
    step();
    set_op(7'b0110011, 3'b100, 1'b0, 3, 4, 0);
    step();
    check("skid_in_ready", 64'(in_ready), 0);
    check("skid_op1_a",    operand1, 1);
    set_op(7'b0110011, 3'b110, 1'b0, 5, 6, 0);
    step();
    check("skid_hold_op1",  operand1, 1);
    check("skid_hold_ctrl", 64'(alu_control), 0);
    check("skid_hold_rdy",  64'(in_ready), 0);
    out_ready = 1'b1;
    step();
    check("order_b_op1",  operand1, 3);
    check("order_b_ctrl", 64'(alu_control), 4'b0100);
    check("order_b_rdy",  64'(in_ready), 1);
    step();
    in_valid = 1'b0;
    check("order_c_op1",  operand1, 5);
    check("order_c_ctrl", 64'(alu_control), 4'b0011);
    step();
    check("order_drain", 64'(out_valid), 0);
    check_perf("stall", 6, 2);

    // AUIPC with forwarding selected: PC wins
    fwd_a_sel = 2'b01; ex_mem_result = 64'h55; pc = 64'h1000;
    set_op(7'b0010111, 3'b000, 1'b0, 64'h11, 64'h22, 64'h2000);
    in_valid = 1'b1;
    step();
    check("auipc_op1",  operand1, 64'h1000);
    check("auipc_op2",  operand2, 64'h2000);
    check("auipc_ctrl", 64'(alu_control), 0);
    // BEQ with rs2 from MEM/WB
    fwd_b_sel = 2'b10; mem_wb_result = 64'h77;
    set_op(7'b1100011, 3'b000, 1'b0, 64'h11, 64'h9, 64'h40);
    step();
    in_valid = 1'b0;
    check("beq_op1",   operand1, 64'h55);
    check("beq_op2",   operand2, 64'h77);
    check("beq_sdata", store_data, 64'h77);
    check("beq_ctrl",  64'(alu_control), 4'b0001);
    out_ready = 1'b0; mem_wb_result = 64'h99; ex_mem_result = 64'h66;
    step();
    check("hold_fwd_op2", operand2, 64'h77);
    check("hold_fwd_op1", operand1, 64'h55);
    out_ready = 1'b1;
    fwd_a_sel = 2'b00; fwd_b_sel = 2'b00;
    step();

    // JAL: pc + 4
    pc = 64'h3000;
    set_op(7'b1101111, 3'b000, 1'b0, 1, 2, 64'h100);
    in_valid = 1'b1;
    step();
    check("jal_op1", operand1, 64'h3000);
    check("jal_op2", operand2, 4);
    // Illegal encodings, then LUI
    set_op(7'b0110011, 3'b011, 1'b0, 1, 2, 0);
    step();
    check("ill_r_flag", 64'(illegal), 1);
    check("ill_r_ctrl", 64'(alu_control), 0);
    set_op(7'b0001111, 3'b000, 1'b0, 1, 2, 0);
    step();
    check("ill_op_flag", 64'(illegal), 1);
    set_op(7'b0110111, 3'b000, 1'b0, 1, 2, 64'hABC000);
    step();
    in_valid = 1'b0;
    check("lui_flag", 64'(illegal), 0);
    check("lui_ctrl", 64'(alu_control), 4'b1000);
    check("lui_op2",  operand2, 64'hABC000);
    step();
    check_perf("mid", 12, 3);

    // SKID + flush with an op offered in the same cycle
    out_ready = 1'b0;
    set_op(7'b0110011, 3'b111, 1'b0, 21, 22, 0);
    in_valid = 1'b1;
    step();
    set_op(7'b0110011, 3'b001, 1'b0, 23, 24, 0);
    step();
    check("pre_flush_rdy", 64'(in_ready), 0);
    flush = 1'b1;
    set_op(7'b0110011, 3'b010, 1'b0, 25, 26, 0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_valid", 64'(out_valid), 0);
    check("flush_rdy",   64'(in_ready), 1);
    check("flush_op1",   operand1, 0);
    out_ready = 1'b1;
    step();
    check("flush_nodeliver", 64'(out_valid), 0);
    check_perf("flush", 12, 5);

    // Reset while in SKID
    out_ready = 1'b0;
    set_op(7'b0110011, 3'b000, 1'b0, 31, 32, 0);
    in_valid = 1'b1;
    step(); step();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_skid_valid", 64'(out_valid), 0);
    check("rst_skid_rdy",   64'(in_ready), 1);
    check_perf("rst_skid", 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
